// File: rtl/out_uart.sv
// Output-port UART: buffers 16-bit words from the core in a FIFO and sends each one as two
// 8N1 frames, high byte first. The block never stalls the core; words that do not fit are dropped.
module out_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     out_en,
  input  logic [15:0]              out_dat,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BitLoad = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] Full    = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic [15:0]     hold_q, hold_d;
  logic            hi_lo_q, hi_lo_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tx_q, tx_d;
  logic            pop, push, bit_done, fifo_nonempty;
  logic [7:0]      byte_d;

  assign fifo_nonempty = (count_q != '0);
  assign bit_done      = (timer_q == '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push          = out_en && ((count_q != Full) || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (out_en && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= out_dat;
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      hi_lo_q   <= 1'b0;
      bit_idx_q <= '0;
      timer_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      hi_lo_q   <= hi_lo_d;
      bit_idx_q <= bit_idx_d;
      timer_q   <= timer_d;
      tx_q      <= tx_d;
    end
  end

  // Transmitter next state
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hi_lo_d   = hi_lo_q;
    bit_idx_d = bit_idx_q;
    timer_d   = bit_done ? timer_q : timer_q - TW'(1);
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          hi_lo_d = 1'b0;
          timer_d = BitLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_idx_d = '0;
          timer_d   = BitLoad;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          timer_d = BitLoad;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          timer_d = BitLoad;
          if (!hi_lo_q) begin
            hi_lo_d = 1'b1;
            state_d = StStart;
          end else if (fifo_nonempty) begin
            pop     = 1'b1;
            hold_d  = mem_q[rd_ptr_q];
            hi_lo_d = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so tx is a clean register output.
  always_comb begin
    byte_d = hi_lo_d ? hold_d[7:0] : hold_d[15:8];
    tx_d   = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle) || fifo_nonempty;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_out_uart.sv
// Self-checking bench for out_uart: a line receiver decodes tx, and a timing model predicts
// which words are accepted and the cycle each frame starts.
module tb_out_uart;

  localparam int CPB   = 4;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int WORD  = 20 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        out_en = 1'b0;
  logic [15:0] out_dat = '0;
  logic        tx, busy, overflow;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  out_uart #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .clk      (clk),
    .reset    (reset),
    .out_en   (out_en),
    .out_dat  (out_dat),
    .tx       (tx),
    .busy     (busy),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: samples on the falling clock edge, mid-bit.
  logic [7:0] rx_q[$];
  int         rx_t_q[$];
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  int         rx_ferr = 0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_act  <= 1'b0;
      rx_cnt  <= 0;
      rx_ferr <= 0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
        rx_t_q.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == CPB / 2 && tx !== 1'b0) rx_ferr <= rx_ferr + 1;
      if ((rx_cnt % CPB) == CPB / 2 && rx_cnt >= CPB && rx_cnt < 9 * CPB)
        rx_sh <= {tx, rx_sh[7:1]};
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        rx_act <= 1'b0;
        rx_q.push_back(rx_sh);
        if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
      end
    end
  end

  // Timing model: each accepted word is popped one edge after arrival when idle, otherwise
  // exactly one word-time after the previous pop.
  logic [7:0] exp_b_q[$];
  int         exp_t_q[$];
  int         mdl_pop_q[$];
  int         mdl_last;
  logic       exp_ovf;

  task automatic mdl_reset();
    exp_b_q.delete();
    exp_t_q.delete();
    mdl_pop_q.delete();
    mdl_last = -100000;
    exp_ovf  = 1'b0;
  endtask

  task automatic mdl_write(input int t, input logic [15:0] w);
    int held = 0;
    bit pop_now = 0;
    int p;
    foreach (mdl_pop_q[i]) begin
      if (mdl_pop_q[i] >= t) held++;
      if (mdl_pop_q[i] == t) pop_now = 1;
    end
    if (held < DEP || pop_now) begin
      p = (t + 1 > mdl_last + WORD) ? t + 1 : mdl_last + WORD;
      mdl_pop_q.push_back(p);
      mdl_last = p;
      exp_b_q.push_back(w[15:8]);
      exp_b_q.push_back(w[7:0]);
      exp_t_q.push_back(p);
      exp_t_q.push_back(p + FRAME);
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  // Called on a falling edge; the word is sampled on the next rising edge.
  task automatic send(input logic [15:0] w);
    out_en  = 1'b1;
    out_dat = w;
    mdl_write(cyc + 1, w);
    @(negedge clk);
    out_en  = 1'b0;
    out_dat = 16'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    out_en = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    rx_t_q.delete();
    mdl_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    rx_t_q.delete();
    mdl_reset();
    @(negedge clk);
    n_checks += 4;
    if (tx !== 1'b1)      begin n_errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    if (busy !== 1'b0)    begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (count !== 3'd0)   begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 5; i++) begin
      out_dat = 16'($urandom);
      @(negedge clk);
    end
    n_checks += 2;
    if (count !== 3'd0 || busy !== 1'b0)
      begin n_errors++; $display("FAIL idle_dat_ignored: got count=%0d busy=%b want 0/0", count, busy); end
    if (tx !== 1'b1)      begin n_errors++; $display("FAIL idle_tx: got %b want 1", tx); end
  endtask

  task automatic test_single();
    logic [15:0] w = 16'h41A5;
    logic [7:0]  b;
    logic        exp_bit;
    int          bad = 0;
    send(w);
    n_checks += 3;
    if (count !== 3'd1) begin n_errors++; $display("FAIL single_count_e0: got %0d want 1", count); end
    if (tx !== 1'b1)    begin n_errors++; $display("FAIL single_tx_e0: got %b want 1", tx); end
    if (busy !== 1'b1)  begin n_errors++; $display("FAIL single_busy_e0: got %b want 1", busy); end
    @(negedge clk);
    n_checks += 1;
    if (count !== 3'd0) begin n_errors++; $display("FAIL single_count_e1: got %0d want 0", count); end
    for (int i = 0; i < WORD; i++) begin
      b = (i < FRAME) ? w[15:8] : w[7:0];
      case ((i % FRAME) / CPB)
        0:       exp_bit = 1'b0;
        9:       exp_bit = 1'b1;
        default: exp_bit = b[(i % FRAME) / CPB - 1];
      endcase
      n_checks++;
      if (tx !== exp_bit) begin
        n_errors++;
        $display("FAIL single_wave[%0d]: got %b want %b", i, tx, exp_bit);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      if (tx !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks += 3;
    if (bad != 0)       begin n_errors++; $display("FAIL single_idle_after: got %0d low cycles want 0", bad); end
    if (busy !== 1'b0)  begin n_errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    if (count !== 3'd0) begin n_errors++; $display("FAIL single_count_end: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_reset();
    send(16'h1234);
    send(16'h5678);
    repeat (2 * WORD + 10) @(negedge clk);
    n_checks += 2;
    if (rx_q.size() != 4) begin n_errors++; $display("FAIL b2b_nbytes: got %0d want 4", rx_q.size()); end
    if (rx_ferr != 0)      begin n_errors++; $display("FAIL b2b_framing: got %0d errors want 0", rx_ferr); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) begin n_errors++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, rx_q[i], exp[i]); end
    end
    for (int i = 0; i + 1 < rx_t_q.size(); i++) begin
      n_checks++;
      if (rx_t_q[i+1] - rx_t_q[i] != FRAME)
        begin n_errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, rx_t_q[i+1] - rx_t_q[i], FRAME); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      send(16'(k + 1));
      if (k == 4) begin
        n_checks += 2;
        if (count !== 3'd4)    begin n_errors++; $display("FAIL ovf_count5: got %0d want 4", count); end
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    n_checks += 2;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    if (count !== 3'd4)    begin n_errors++; $display("FAIL ovf_count6: got %0d want 4", count); end
    repeat (5 * WORD + 20) @(negedge clk);
    n_checks += 3;
    if (rx_q.size() != 10) begin n_errors++; $display("FAIL ovf_nbytes: got %0d want 10", rx_q.size()); end
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    if (busy !== 1'b0)     begin n_errors++; $display("FAIL ovf_busy_end: got %b want 0", busy); end
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== ((i % 2 == 0) ? 8'h00 : 8'(i / 2 + 1)))
        begin n_errors++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, rx_q[i], (i % 2 == 0) ? 8'h00 : 8'(i / 2 + 1)); end
    end
  endtask

  task automatic test_push_full_pop();
    int t_pop2;
    do_reset();
    t_pop2 = cyc + 2 + WORD;
    for (int k = 0; k < 5; k++) send(16'hA000 + 16'(k));
    while (cyc < t_pop2 - 1) @(negedge clk);
    n_checks++;
    if (count !== 3'd4) begin n_errors++; $display("FAIL fullpop_pre: got %0d want 4", count); end
    send(16'hBEEF);
    n_checks += 2;
    if (count !== 3'd4)    begin n_errors++; $display("FAIL fullpop_count: got %0d want 4", count); end
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    repeat (5 * WORD + 20) @(negedge clk);
    n_checks += 2;
    if (rx_q.size() != 12) begin n_errors++; $display("FAIL fullpop_nbytes: got %0d want 12", rx_q.size()); end
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL fullpop_ovf_end: got %b want 0", overflow); end
    for (int i = 0; i < exp_b_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_b_q[i]) begin n_errors++; $display("FAIL fullpop_byte[%0d]: got %h want %h", i, rx_q[i], exp_b_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    send(16'h0055);
    send(16'h0077);
    repeat (10) @(negedge clk);
    n_checks += 2;
    if (tx !== 1'b0)    begin n_errors++; $display("FAIL mid_tx_before: got %b want 0", tx); end
    if (count !== 3'd1) begin n_errors++; $display("FAIL mid_count_before: got %0d want 1", count); end
    reset = 1'b0;
    #1;
    n_checks += 3;
    if (tx !== 1'b1)    begin n_errors++; $display("FAIL mid_tx_async: got %b want 1", tx); end
    if (count !== 3'd0) begin n_errors++; $display("FAIL mid_count_async: got %0d want 0", count); end
    if (busy !== 1'b0)  begin n_errors++; $display("FAIL mid_busy_async: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    rx_t_q.delete();
    mdl_reset();
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_checks += 3;
    if (bad != 0)       begin n_errors++; $display("FAIL mid_idle_after: got %0d low cycles want 0", bad); end
    if (busy !== 1'b0)  begin n_errors++; $display("FAIL mid_busy_after: got %b want 0", busy); end
    if (rx_q.size() != 0) begin n_errors++; $display("FAIL mid_rx_after: got %0d bytes want 0", rx_q.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 12; n++) begin
      send(16'h0100 + 16'(n));
      repeat ($urandom_range(70, 100) - 1) @(negedge clk);
    end
    repeat (2 * WORD + 20) @(negedge clk);
    n_checks += 3;
    if (rx_q.size() != 24) begin n_errors++; $display("FAIL wrap_nbytes: got %0d want 24", rx_q.size()); end
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
    if (rx_ferr != 0)      begin n_errors++; $display("FAIL wrap_framing: got %0d want 0", rx_ferr); end
    for (int i = 0; i < 24 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== ((i % 2 == 0) ? 8'h01 : 8'(i / 2)))
        begin n_errors++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, rx_q[i], (i % 2 == 0) ? 8'h01 : 8'(i / 2)); end
    end
    for (int i = 0; i < exp_t_q.size() && i < rx_t_q.size(); i++) begin
      n_checks++;
      if (rx_t_q[i] != exp_t_q[i]) begin n_errors++; $display("FAIL wrap_start[%0d]: got %0d want %0d", i, rx_t_q[i], exp_t_q[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 30; n++) begin
      send(16'($urandom));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    while (cyc < mdl_last + WORD + 10) @(negedge clk);
    n_checks += 6;
    if (rx_q.size() != exp_b_q.size())
      begin n_errors++; $display("FAIL rand_nbytes: got %0d want %0d", rx_q.size(), exp_b_q.size()); end
    if (rx_t_q.size() != exp_t_q.size())
      begin n_errors++; $display("FAIL rand_nframes: got %0d want %0d", rx_t_q.size(), exp_t_q.size()); end
    if (overflow !== exp_ovf) begin n_errors++; $display("FAIL rand_ovf: got %b want %b", overflow, exp_ovf); end
    if (busy !== 1'b0)        begin n_errors++; $display("FAIL rand_busy: got %b want 0", busy); end
    if (count !== 3'd0)       begin n_errors++; $display("FAIL rand_count: got %0d want 0", count); end
    if (rx_ferr != 0)         begin n_errors++; $display("FAIL rand_framing: got %0d want 0", rx_ferr); end
    for (int i = 0; i < exp_b_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_b_q[i]) begin n_errors++; $display("FAIL rand_byte[%0d]: got %h want %h", i, rx_q[i], exp_b_q[i]); end
    end
    for (int i = 0; i < exp_t_q.size() && i < rx_t_q.size(); i++) begin
      n_checks++;
      if (rx_t_q[i] != exp_t_q[i]) begin n_errors++; $display("FAIL rand_start[%0d]: got %0d want %0d", i, rx_t_q[i], exp_t_q[i]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_full_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
